// File: rtl/silife_pkg.sv
// Shared types, framing helpers and the byte-select mux for the life grid reader.
package silife_pkg;

    localparam int unsigned FRAME_COUNT_W = 16;
    // Largest grid the byte-select mux has to cover (64 x 64 cells).
    localparam int unsigned MAX_CELLS     = 4096;
    localparam int unsigned CELL_IDX_W    = $clog2(MAX_CELLS);

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // Packed bytes needed to cover one row of the given width.
    function automatic int unsigned bytes_per_row(input int unsigned width);
        return (width + 7) / 8;
    endfunction

    // Byte k of a frame: row k/bpr, columns 8*(k%bpr)+i. Columns past the grid edge read 0.
    function automatic logic [7:0] select_byte(input logic [MAX_CELLS-1:0] snap,
                                               input int unsigned          width,
                                               input int unsigned          bpr,
                                               input logic [15:0]          idx);
        logic [7:0]            b;
        int unsigned           row;
        int unsigned           col0;
        int unsigned           col;
        logic [CELL_IDX_W-1:0] bit_idx;
        b    = '0;
        row  = {16'd0, idx} / bpr;
        col0 = 8 * ({16'd0, idx} % bpr);
        for (int i = 0; i < 8; i++) begin
            col = col0 + i;
            if (col < width) begin
                bit_idx = CELL_IDX_W'(row * width + col);
                b[i]    = snap[bit_idx];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/silife_grid_reader.sv
// Snapshots the life grid in one cycle and streams it out row by row as packed bytes over a
// valid/ready interface, so the grid can keep evolving while the frame drains.
module silife_grid_reader
    import silife_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned HEIGHT = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH*HEIGHT-1:0]  cells,
    input  logic                     start,
    output logic                     busy,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [FRAME_COUNT_W-1:0] frame_count
);

    localparam int unsigned NCELLS = WIDTH * HEIGHT;
    localparam int unsigned BPR    = bytes_per_row(WIDTH);
    localparam int unsigned NBYTES = HEIGHT * BPR;
    localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NBYTES - 1);

    state_e                   state_q, state_d;
    logic [NCELLS-1:0]        snapshot_q, snapshot_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         idx_next;
    logic [7:0]               data_q, data_d;
    logic                     last_q, last_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;

    assign idx_next = idx_q + 1'b1;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            snapshot_q    <= '0;
            idx_q         <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            snapshot_q    <= snapshot_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            last_q        <= last_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next state: capture on start, advance one byte per accepted handshake.
    always_comb begin
        state_d       = state_q;
        snapshot_d    = snapshot_q;
        idx_d         = idx_q;
        data_d        = data_q;
        last_d        = last_q;
        frame_count_d = frame_count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snapshot_d = cells;
                    idx_d      = '0;
                    data_d     = select_byte(MAX_CELLS'(cells), WIDTH, BPR, 16'd0);
                    last_d     = (NBYTES == 1);
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d       = StIdle;
                        idx_d         = '0;
                        data_d        = '0;
                        last_d        = 1'b0;
                        frame_count_d = frame_count_q + 1'b1;
                    end else begin
                        idx_d  = idx_next;
                        data_d = select_byte(MAX_CELLS'(snapshot_q), WIDTH, BPR, 16'(idx_next));
                        last_d = (idx_next == LastIdx);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from registered state.
    always_comb begin
        busy        = (state_q == StSend);
        out_valid   = (state_q == StSend);
        out_data    = data_q;
        out_last    = last_q;
        frame_count = frame_count_q;
    end

endmodule

// File: tb/tb_silife_grid_reader.sv
// Scoreboard bench: stimulus pushes expected bytes, per-DUT monitors pop on each handshake.
module tb_silife_grid_reader;
    import silife_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 8x8
    logic [63:0] cells_a = '0;
    logic        start_a = 1'b0, ready_a = 1'b0;
    logic        busy_a, valid_a, last_a;
    logic [7:0]  data_a;
    logic [15:0] fc_a;

    // DUT B: 10x2
    logic [19:0] cells_b = '0;
    logic        start_b = 1'b0, ready_b = 1'b0;
    logic        busy_b, valid_b, last_b;
    logic [7:0]  data_b;
    logic [15:0] fc_b;

    silife_grid_reader #(.WIDTH(8), .HEIGHT(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .cells(cells_a), .start(start_a), .busy(busy_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
        .frame_count(fc_a)
    );

    silife_grid_reader #(.WIDTH(10), .HEIGHT(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .cells(cells_b), .start(start_b), .busy(busy_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
        .frame_count(fc_b)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_a  = 0;
    int   hs_b  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor A: compares each accepted byte and checks that stalled bytes hold.
    exp_t       e_a;
    logic [7:0] prev_data_a = '0;
    logic       prev_last_a = 1'b0;
    logic       prev_stall_a = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall_a && valid_a) begin
                check("A hold data", 32'(data_a), 32'(prev_data_a));
                check("A hold last", 32'(last_a), 32'(prev_last_a));
            end
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL A extra byte: got 0x%0h expected none", data_a);
                end else begin
                    e_a = q_a.pop_front();
                    check("A data", 32'(data_a), 32'(e_a.data));
                    check("A last", 32'(last_a), 32'(e_a.last));
                end
                hs_a++;
            end
            prev_stall_a = valid_a && !ready_a;
            prev_data_a  = data_a;
            prev_last_a  = last_a;
        end else begin
            prev_stall_a = 1'b0;
        end
    end

    // Monitor B
    exp_t e_b;
    always @(negedge clk) begin
        if (reset_n && valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL B extra byte: got 0x%0h expected none", data_b);
            end else begin
                e_b = q_b.pop_front();
                check("B data", 32'(data_b), 32'(e_b.data));
                check("B last", 32'(last_b), 32'(e_b.last));
            end
            hs_b++;
        end
    end

    // Diagonal pattern: row r = 0x01 << r.
    task automatic load_diag();
        for (int r = 0; r < 8; r++) begin
            cells_a[r*8 +: 8] = 8'h01 << r;
        end
    endtask

    task automatic push_diag();
        for (int k = 0; k < 8; k++) begin
            q_a.push_back('{data: 8'h01 << k, last: (k == 7)});
        end
    endtask

    // Pulse start on A, then drain. stall: ready pattern 1,0,0 repeating.
    // mid_cells/mid_start: change cells next cycle and re-pulse start mid-frame.
    task automatic frame_a(input bit stall, input bit mid_cells, input bit mid_start,
                           output int cycles);
        int c;
        @(posedge clk) #1;
        start_a = 1'b1;
        ready_a = stall ? 1'b1 : 1'b1;
        @(posedge clk) #1;
        start_a = 1'b0;
        check("A latency valid", 32'(valid_a), 32'd1);
        check("A latency busy", 32'(busy_a), 32'd1);
        if (mid_cells) cells_a = '1;
        cycles = 0;
        c = 0;
        while (busy_a && cycles < 200) begin
            ready_a = stall ? (c % 3 == 0) : 1'b1;
            start_a = mid_start && (c == 3);
            @(posedge clk) #1;
            c++;
            cycles++;
        end
        start_a = 1'b0;
        ready_a = 1'b0;
        if (cycles >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL A frame timeout: got %0d cycles required < 200", cycles);
        end
    endtask

    int cyc;
    int h0;
    int t;

    initial begin
        #12;
        // Reset state
        check("A rst busy", 32'(busy_a), 32'd0);
        check("A rst valid", 32'(valid_a), 32'd0);
        check("A rst last", 32'(last_a), 32'd0);
        check("A rst data", 32'(data_a), 32'd0);
        check("A rst fc", 32'(fc_a), 32'd0);
        check("B rst fc", 32'(fc_b), 32'd0);
        @(posedge clk) #1;
        reset_n = 1'b1;

        // Diagonal frame, ready held high
        load_diag();
        push_diag();
        h0 = hs_a;
        frame_a(1'b0, 1'b0, 1'b0, cyc);
        check("A full-rate cycles", 32'(cyc), 32'd8);
        check("A hs count 1", 32'(hs_a - h0), 32'd8);
        check("A fc after 1", 32'(fc_a), 32'd1);
        check("A busy after 1", 32'(busy_a), 32'd0);

        // Same grid with stalls
        push_diag();
        h0 = hs_a;
        frame_a(1'b1, 1'b0, 1'b0, cyc);
        check("A hs count stall", 32'(hs_a - h0), 32'd8);
        check("A fc after stall", 32'(fc_a), 32'd2);

        // 10x2 all ones: padding bits in the second byte of each row read 0
        cells_b = '1;
        q_b.push_back('{data: 8'hFF, last: 1'b0});
        q_b.push_back('{data: 8'h03, last: 1'b0});
        q_b.push_back('{data: 8'hFF, last: 1'b0});
        q_b.push_back('{data: 8'h03, last: 1'b1});
        h0 = hs_b;
        @(posedge clk) #1;
        start_b = 1'b1;
        ready_b = 1'b1;
        @(posedge clk) #1;
        start_b = 1'b0;
        t = 0;
        while (busy_b && t < 100) begin
            @(posedge clk) #1;
            t++;
        end
        ready_b = 1'b0;
        check("B cycles", 32'(t), 32'd4);
        check("B hs count", 32'(hs_b - h0), 32'd4);
        check("B fc", 32'(fc_b), 32'd1);

        // Snapshot isolation and ignored mid-frame start
        cells_a = '0;
        for (int k = 0; k < 8; k++) q_a.push_back('{data: 8'h00, last: (k == 7)});
        h0 = hs_a;
        frame_a(1'b0, 1'b1, 1'b1, cyc);
        repeat (4) @(posedge clk);
        #1;
        check("A no second frame busy", 32'(busy_a), 32'd0);
        check("A no second frame valid", 32'(valid_a), 32'd0);
        check("A hs count iso", 32'(hs_a - h0), 32'd8);
        check("A fc after iso", 32'(fc_a), 32'd3);

        // Reset mid-frame after 3 accepted bytes
        load_diag();
        push_diag();
        h0 = hs_a;
        @(posedge clk) #1;
        start_a = 1'b1;
        ready_a = 1'b1;
        @(posedge clk) #1;
        start_a = 1'b0;
        t = 0;
        while ((hs_a - h0) < 3 && t < 50) begin
            @(posedge clk) #1;
            t++;
        end
        reset_n = 1'b0;
        #1;
        check("A midrst valid", 32'(valid_a), 32'd0);
        check("A midrst busy", 32'(busy_a), 32'd0);
        check("A midrst fc", 32'(fc_a), 32'd0);
        check("A midrst bytes", 32'(hs_a - h0), 32'd3);
        q_a.delete();
        ready_a = 1'b0;
        @(posedge clk) #1;
        reset_n = 1'b1;
        push_diag();
        h0 = hs_a;
        frame_a(1'b0, 1'b0, 1'b0, cyc);
        check("A post-rst hs", 32'(hs_a - h0), 32'd8);
        check("A post-rst fc", 32'(fc_a), 32'd1);

        // frame_count wrap
        @(posedge clk) #1;
        force dut_a.frame_count_q = 16'hFFFF;
        @(posedge clk) #1;
        release dut_a.frame_count_q;
        @(posedge clk) #1;
        check("A fc forced", 32'(fc_a), 32'h0000FFFF);
        push_diag();
        frame_a(1'b0, 1'b0, 1'b0, cyc);
        check("A fc wrap", 32'(fc_a), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("A queue drained", 32'(q_a.size()), 32'd0);
        check("B queue drained", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
